// File: rtl/reaction_game_if.sv
// Button/tick inputs and display/status outputs of the reaction-time game sequencer.
// The game controller uses the slave modport and its driver uses the master modport.
interface reaction_game_if;
    logic       tick;
    logic       btn_start;
    logic       btn_stop;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [1:0] state;
    logic       go_led;
    logic       foul;

    modport master (
        output tick, btn_start, btn_stop,
        input  tens, ones, state, go_led, foul
    );

    modport slave (
        input  tick, btn_start, btn_stop,
        output tens, ones, state, go_led, foul
    );
endinterface

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game sequencer: button synchronisers, random start delay from an LFSR,
// and a two-digit BCD count of tenths. All outputs are registered.
module reaction_game_ctrl #(
    parameter int unsigned DELAY_MIN  = 10,
    parameter logic [7:0]  DELAY_MASK = 8'h1F,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    reaction_game_if.slave gif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GO   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [7:0] DELAY_BASE = 8'(DELAY_MIN);
    localparam logic [3:0] BLANK      = 4'hF;

    // Fibonacci feedback for taps 8,6,5,4: parity of the tapped bits.
    function automatic logic lfsr_feedback(input logic [7:0] v);
        return v[7] ^ v[5] ^ v[4] ^ v[3];
    endfunction

    logic [2:0] start_sync_r;
    logic [2:0] stop_sync_r;
    logic       start_press_r;
    logic       stop_press_r;
    logic [7:0] lfsr_r;
    state_t     state_r, state_s;
    logic [7:0] delay_r, delay_s;
    logic [3:0] cnt_tens_r, cnt_tens_s;
    logic [3:0] cnt_ones_r, cnt_ones_s;
    logic       foul_r, foul_s;
    logic [3:0] tens_r, tens_s;
    logic [3:0] ones_r, ones_s;
    logic       go_led_r;

    // Synchronise both buttons and register a one-clk pulse on each rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sync_r  <= 3'b000;
            stop_sync_r   <= 3'b000;
            start_press_r <= 1'b0;
            stop_press_r  <= 1'b0;
        end else begin
            start_sync_r  <= {start_sync_r[1:0], gif.btn_start};
            stop_sync_r   <= {stop_sync_r[1:0], gif.btn_stop};
            start_press_r <= start_sync_r[1] & ~start_sync_r[2];
            stop_press_r  <= stop_sync_r[1] & ~stop_sync_r[2];
        end
    end

    // Free-running random source; frozen with the rest of the game while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= LFSR_SEED;
        end else if (ena) begin
            lfsr_r <= {lfsr_r[6:0], lfsr_feedback(lfsr_r)};
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    // Game sequencing; stop beats a simultaneous tick, and start beats stop in IDLE.
    always_comb begin
        state_s    = state_r;
        delay_s    = delay_r;
        cnt_tens_s = cnt_tens_r;
        cnt_ones_s = cnt_ones_r;
        foul_s     = foul_r;
        if (ena) begin
            case (state_r)
                ST_IDLE: begin
                    if (start_press_r) begin
                        delay_s = DELAY_BASE + (lfsr_r & DELAY_MASK);
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (stop_press_r) begin
                        foul_s  = 1'b1;
                        state_s = ST_DONE;
                    end else if (gif.tick) begin
                        delay_s = delay_r - 8'd1;
                        if (delay_r == 8'd1) begin
                            cnt_tens_s = 4'd0;
                            cnt_ones_s = 4'd0;
                            state_s    = ST_GO;
                        end else begin
                            state_s = ST_WAIT;
                        end
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_GO: begin
                    if (stop_press_r) begin
                        state_s = ST_DONE;
                    end else if (gif.tick) begin
                        if ((cnt_tens_r == 4'd9) && (cnt_ones_r == 4'd9)) begin
                            state_s = ST_DONE;
                        end else if (cnt_ones_r == 4'd9) begin
                            cnt_ones_s = 4'd0;
                            cnt_tens_s = cnt_tens_r + 4'd1;
                        end else begin
                            cnt_ones_s = cnt_ones_r + 4'd1;
                        end
                    end else begin
                        state_s = ST_GO;
                    end
                end
                ST_DONE: begin
                    if (start_press_r) begin
                        foul_s  = 1'b0;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end

        if ((state_s == ST_GO) || ((state_s == ST_DONE) && !foul_s)) begin
            tens_s = cnt_tens_s;
            ones_s = cnt_ones_s;
        end else begin
            tens_s = BLANK;
            ones_s = BLANK;
        end
    end

    // State, counters and display registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            delay_r    <= 8'd0;
            cnt_tens_r <= 4'd0;
            cnt_ones_r <= 4'd0;
            foul_r     <= 1'b0;
            tens_r     <= BLANK;
            ones_r     <= BLANK;
            go_led_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            delay_r    <= delay_s;
            cnt_tens_r <= cnt_tens_s;
            cnt_ones_r <= cnt_ones_s;
            foul_r     <= foul_s;
            tens_r     <= tens_s;
            ones_r     <= ones_s;
            go_led_r   <= (state_s == ST_GO);
        end
    end

    assign gif.tens   = tens_r;
    assign gif.ones   = ones_r;
    assign gif.state  = state_r;
    assign gif.go_led = go_led_r;
    assign gif.foul   = foul_r;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Bench for reaction_game_ctrl: directed game rounds plus a randomized phase, all checked
// every cycle against an event-level model of the game rules.
module tb_reaction_game_ctrl;

    localparam int         DELAY_MIN = 10;
    localparam logic [7:0] MASK      = 8'h1F;
    localparam logic [7:0] SEED      = 8'hA5;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic ena       = 1'b0;
    logic tick_man  = 1'b0;
    logic btn_start = 1'b0;
    logic btn_stop  = 1'b0;
    logic cmp_en    = 1'b0;

    int checks = 0;
    int passes = 0;
    int n_a, n_b, n_t;

    reaction_game_if gif();
    assign gif.tick      = tick_man;
    assign gif.btn_start = btn_start;
    assign gif.btn_stop  = btn_stop;

    reaction_game_ctrl #(
        .DELAY_MIN (DELAY_MIN),
        .DELAY_MASK(MASK),
        .LFSR_SEED (SEED)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .gif  (gif)
    );

    always #5 clk = ~clk;

    // Game model: st 0..3, elapsed tenths as a plain integer, raw button history newest-first.
    typedef struct packed {
        int         st;
        int         delay;
        int         elapsed;
        int         last_delay;
        logic       foul;
        logic [7:0] lfsr;
        logic [3:0] hs_start;
        logic [3:0] hs_stop;
    } model_t;

    model_t m;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.st = 0; r.delay = 0; r.elapsed = 0; r.last_delay = 0;
        r.foul = 1'b0; r.lfsr = SEED; r.hs_start = 4'b0000; r.hs_stop = 4'b0000;
        return r;
    endfunction

    // A press acts three edges after the raw level is first sampled high.
    function automatic model_t model_step(input model_t c, input logic en, input logic tk,
                                          input logic rs, input logic rp);
        model_t n;
        logic ps, pp;
        n = c;
        ps = c.hs_start[2] & ~c.hs_start[3];
        pp = c.hs_stop[2] & ~c.hs_stop[3];
        n.hs_start = {c.hs_start[2:0], rs};
        n.hs_stop  = {c.hs_stop[2:0], rp};
        if (en) begin
            n.lfsr = lfsr_next(c.lfsr);
            if (c.st == 0) begin
                if (ps) begin
                    n.delay = DELAY_MIN + int'(c.lfsr & MASK);
                    n.last_delay = n.delay;
                    n.st = 1;
                end
            end else if (c.st == 1) begin
                if (pp) begin
                    n.foul = 1'b1;
                    n.st = 3;
                end else if (tk) begin
                    n.delay = c.delay - 1;
                    if (n.delay == 0) begin
                        n.elapsed = 0;
                        n.st = 2;
                    end
                end
            end else if (c.st == 2) begin
                if (pp) n.st = 3;
                else if (tk) begin
                    if (c.elapsed == 99) n.st = 3;
                    else n.elapsed = c.elapsed + 1;
                end
            end else begin
                if (ps) begin
                    n.st = 0;
                    n.foul = 1'b0;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_step(m, ena, tick_man, btn_start, btn_stop);
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic       show;
        logic [3:0] e_tens, e_ones;
        logic       e_go;
        if (cmp_en) begin
            show   = (m.st == 2) || ((m.st == 3) && !m.foul);
            e_tens = show ? 4'(m.elapsed / 10) : 4'hF;
            e_ones = show ? 4'(m.elapsed % 10) : 4'hF;
            e_go   = (m.st == 2);
            checks++;
            if ((int'(gif.state) != m.st) || (gif.tens !== e_tens) || (gif.ones !== e_ones) ||
                (gif.go_led !== e_go) || (gif.foul !== m.foul)) begin
                $display("FAIL cycle_cmp t=%0t: got state=%0d tens=%h ones=%h go=%b foul=%b, required state=%0d tens=%h ones=%h go=%b foul=%b",
                         $time, gif.state, gif.tens, gif.ones, gif.go_led, gif.foul,
                         m.st, e_tens, e_ones, e_go, m.foul);
            end else begin
                passes++;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0d, required %0d", name, act, exp);
        else passes++;
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input bit stop);
        if (stop) btn_stop = 1'b1; else btn_start = 1'b1;
        clks(4);
        btn_stop  = 1'b0;
        btn_start = 1'b0;
        clks(4);
    endtask

    task automatic send_ticks(input int n);
        repeat (n) begin
            tick_man = 1'b1;
            clks(1);
            tick_man = 1'b0;
            clks(3);
        end
    endtask

    task automatic run_until_go(output int n);
        n = 0;
        while (!gif.go_led && n < 60) begin
            send_ticks(1);
            n++;
        end
    endtask

    // Stop pulse lands on the same edge as a tick.
    task automatic stop_with_tick();
        btn_stop = 1'b1;
        clks(3);
        tick_man = 1'b1;
        clks(1);
        tick_man = 1'b0;
        btn_stop = 1'b0;
        clks(4);
    endtask

    task automatic chk_out(input string name, input int st, input int t, input int o,
                           input int go, input int fl);
        chk({name, "_state"}, int'(gif.state), st);
        chk({name, "_tens"}, int'(gif.tens), t);
        chk({name, "_ones"}, int'(gif.ones), o);
        chk({name, "_go"}, int'(gif.go_led), go);
        chk({name, "_foul"}, int'(gif.foul), fl);
    endtask

    initial begin
        chk("lfsr_model_a5", int'(lfsr_next(8'hA5)), 8'h4A);
        chk("lfsr_model_4a", int'(lfsr_next(8'h4A)), 8'h95);

        ena = 1'b1;
        clks(3);
        chk_out("por", 0, 15, 15, 0, 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Round A, interrupted by reset at count 37.
        clks(5);
        press(1'b0);
        chk("round_a_wait", int'(gif.state), 1);
        run_until_go(n_a);
        chk("wait_in_range", int'(n_a >= 10 && n_a <= 41), 1);
        chk("wait_equals_load", n_a, m.last_delay);
        send_ticks(37);
        chk_out("count37", 2, 3, 7, 1, 0);
        rst_n = 1'b0;
        #1;
        chk_out("reset_mid_go", 0, 15, 15, 0, 0);
        clks(2);
        rst_n = 1'b1;

        // Round B replays the LFSR from the seed, then a normal 23-tick result.
        clks(5);
        press(1'b0);
        run_until_go(n_b);
        chk("lfsr_replay", n_b, n_a);
        send_ticks(23);
        press(1'b1);
        chk_out("normal", 3, 2, 3, 0, 0);

        // False start.
        press(1'b0);
        chk("done_to_idle", int'(gif.state), 0);
        press(1'b0);
        send_ticks(2);
        press(1'b1);
        chk_out("false_start", 3, 15, 15, 0, 1);
        press(1'b0);
        chk_out("foul_cleared", 0, 15, 15, 0, 0);

        // Timeout at 99.
        press(1'b0);
        run_until_go(n_t);
        send_ticks(99);
        chk_out("count99", 2, 9, 9, 1, 0);
        send_ticks(1);
        chk_out("timeout", 3, 9, 9, 0, 0);

        // Stop and tick together at 09.
        press(1'b0);
        press(1'b0);
        run_until_go(n_t);
        send_ticks(9);
        stop_with_tick();
        chk_out("stop_beats_tick", 3, 0, 9, 0, 0);

        // Start and stop together in IDLE, then stop with the final WAIT tick.
        press(1'b0);
        btn_start = 1'b1;
        btn_stop  = 1'b1;
        clks(4);
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        clks(4);
        chk("start_beats_stop", int'(gif.state), 1);
        send_ticks(m.last_delay - 1);
        stop_with_tick();
        chk_out("foul_beats_go", 3, 15, 15, 0, 1);

        // Freeze in GO with ticks and a stop press while disabled.
        press(1'b0);
        press(1'b0);
        run_until_go(n_t);
        send_ticks(5);
        ena = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick_man = (i % 4 == 0);
            btn_stop = (i >= 10 && i < 14);
            clks(1);
        end
        tick_man = 1'b0;
        btn_stop = 1'b0;
        ena = 1'b1;
        clks(4);
        chk_out("ena_freeze", 2, 0, 5, 1, 0);
        press(1'b1);
        btn_stop = 1'b1;
        clks(1000);
        chk_out("stop_held", 3, 0, 5, 0, 0);
        btn_stop = 1'b0;
        clks(4);

        // Randomized play.
        for (int i = 0; i < 4000; i++) begin
            tick_man = ($urandom_range(0, 3) == 0);
            ena      = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 29) == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 19) == 0) btn_stop = ~btn_stop;
            clks(1);
        end
        tick_man  = 1'b0;
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        ena       = 1'b1;
        clks(5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/reaction_game_ctrl.md
# reaction_game_ctrl

Sequencer for the reaction-time game: synchronises the two player buttons, runs the IDLE/WAIT/GO/DONE state machine and times the player in tenths of a second as a two-digit BCD count. It sits between the button inputs, the tenths tick from the clock divider, and the dual seven-segment driver. It feeds that driver the tens/ones digits directly; 4'hF blanks a digit.

## Interface
- DELAY_MIN, 10: minimum random wait, in tenths ticks (≥1)
- DELAY_MASK, 8'h1F: mask applied to the LFSR to form the random extra wait
- LFSR_SEED, 8'hA5: reset value of the 8-bit LFSR (must be nonzero)

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  design enable; low freezes the game
- tick  in  1  one-clk pulse per tenth of a second from the divider
- btn_start  in  1  raw start/clear button, asynchronous to clk
- btn_stop  in  1  raw stop (react) button, asynchronous to clk
- tens  out  4  BCD tens digit to display, 4'hF = blank
- ones  out  4  BCD ones digit to display, 4'hF = blank
- state  out  2  0 IDLE, 1 WAIT, 2 GO, 3 DONE
- go_led  out  1  high only in GO
- foul  out  1  high in DONE after a false start

## Operation
- Each button passes through a 2-flop synchroniser plus a third flop. A press is a one-clk pulse on the synchronised rising edge. Holding a button gives exactly one pulse.
- 8-bit Fibonacci LFSR, taps 8,6,5,4, shifts every clk while ena=1; reset value LFSR_SEED; never all-zero.
- IDLE: tens=ones=F, foul=0.
  - start press: load delay_cnt = DELAY_MIN + (lfsr & DELAY_MASK) (8-bit, no overflow at defaults), go to WAIT.
  - stop press: ignored.
- WAIT: display blank.
  - Each tick decrements delay_cnt. A tick with delay_cnt==1 clears the count to 00 and goes to GO.
  - stop press: foul=1, go to DONE; the display stays blank.
  - start press: ignored.
- GO: go_led=1; the display shows the live count.
  - Each tick adds 1 in BCD: ones 9 wraps to 0 with a tens carry.
  - A tick at 99 holds 99 and goes to DONE (timeout).
  - stop press: freeze the count and go to DONE.
  - start press: ignored.
- DONE: the display holds the result (or blank if foul).
  - start press: go to IDLE, clearing foul and blanking the digits.
  - stop press: ignored.
- Simultaneous events:
  - Stop pulse and tick in the same GO cycle: stop wins and the count is not incremented.
  - Stop pulse and the final tick in WAIT: foul wins.
  - Start and stop pulses together in IDLE: start wins.
- ena=0: state, delay_cnt, count, LFSR and outputs hold. Synchroniser flops keep sampling, so a press made while disabled produces no pulse after ena returns.
- Reset in any state returns to IDLE immediately.

## Timing
- Reset values: state=0, tens=4'hF, ones=4'hF, go_led=0, foul=0, LFSR=LFSR_SEED, delay_cnt=0.
- All outputs are registered; no combinational path from any input to any output.
- Button latency: a raw input first sampled high at edge N produces a press pulse after edge N+2. The state changes at edge N+3.
- Tick latency: the count and state update at the edge that samples tick=1. The new value is visible one clk later.
- Wait length: exactly the loaded delay_cnt ticks after the start press. That is 10..41 ticks at the defaults.
- go_led and state change on the same edge; tens/ones clear to 0 on that same edge when entering GO.

## Test plan
- Reset: assert rst_n=0 mid-GO with count 37 -> immediately state=0, tens=ones=F, go_led=0, foul=0; after release, the same LFSR sequence as from power-up.
- Normal round (tick every 4 clks): start press, wait for go_led, send 23 ticks, then stop -> state=3, tens=2, ones=3, foul=0. The number of ticks in WAIT lies in 10..41 and equals DELAY_MIN + (lfsr & 8'h1F) sampled at the press.
- False start: stop press during WAIT -> state=3, foul=1, tens=ones=F, go_led=0; start press -> state=0, foul=0.
- Timeout: no stop in GO, 100 ticks -> count runs 00..99, state=3 at the 100th tick, display held at 99.
- Simultaneous: stop pulse and tick on the same clk at count 09 -> result 09, not 10. Start+stop pulses together in IDLE -> state=1.
- Enable and debounce:
  - Drop ena for 50 clks in GO, with ticks and a stop press during that time -> count and state are unchanged afterwards.
  - Hold btn_stop high for 1000 clks in DONE -> no state change.
